// File: rtl/alu_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_rr_arbiter: round-robin sharing of one ALU between two valid/ready      |
// | requesters; ALU_ARB_STATS_EN adds per-requester grant counters. Rev 1.0     |
// +----------------------------------------------------------------------------+
module alu_rr_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  input  logic [2:0]        req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  input  logic [2:0]        req1_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_eq,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_eq,
`ifdef ALU_ARB_STATS_EN
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  grant0_cnt,
  output logic [CNT_W-1:0]  grant1_cnt,
`endif
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [DATA_W-1:0] alu_imm,
  output logic              alu_src,
  output logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_eq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_grant;
  logic                r_grant;
  logic [DATA_W-1:0]   r_op1;
  logic [DATA_W-1:0]   r_op2;
  logic [2:0]          r_ctrl;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_eq;
  logic                w_any;
  logic                w_sel;
  logic                w_accept;
  logic                w_rsp_hs;

  always_comb begin
    w_any       = req0_valid | req1_valid;
    // Contention goes to whoever was not served last; otherwise the lone requester.
    w_sel       = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    w_accept    = (r_state == S_IDLE) && w_any;
    w_rsp_hs    = (r_state == S_RESP) && (r_grant ? rsp1_ready : rsp0_ready);
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (w_rsp_hs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_ctrl       <= '0;
      r_rsp_data   <= '0;
      r_rsp_eq     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_grant      <= w_sel;
        r_last_grant <= w_sel;
        r_op1        <= w_sel ? req1_op1  : req0_op1;
        r_op2        <= w_sel ? req1_op2  : req0_op2;
        r_ctrl       <= w_sel ? req1_ctrl : req0_ctrl;
      end
      if (r_state == S_EXEC) begin
        r_rsp_data <= alu_out;
        r_rsp_eq   <= alu_eq;
      end
    end
  end

  assign req0_ready = w_accept & ~w_sel;
  assign req1_ready = w_accept &  w_sel;
  assign rsp0_valid = (r_state == S_RESP) & ~r_grant;
  assign rsp1_valid = (r_state == S_RESP) &  r_grant;
  assign rsp0_data  = r_rsp_data;
  assign rsp1_data  = r_rsp_data;
  assign rsp0_eq    = r_rsp_eq;
  assign rsp1_eq    = r_rsp_eq;

  // ALU inputs come straight from registers, so they only move on a grant edge.
  assign alu_op1  = r_op1;
  assign alu_op2  = r_op2;
  assign alu_ctrl = r_ctrl;
  assign alu_imm  = '0;
  assign alu_src  = 1'b0;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (stats_clr) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (req0_valid && req0_ready) r_cnt0 <= r_cnt0 + 1'b1;
      if (req1_valid && req1_ready) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign grant0_cnt = r_cnt0;
  assign grant1_cnt = r_cnt1;
`else
  localparam int c_unused_cnt_w = CNT_W;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_alu_rr_arbiter: randomized self-checking bench with an ALU and           |
// | arbitration reference model. Rev 1.0                                        |
// +----------------------------------------------------------------------------+
module tb_alu_rr_arbiter;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [1:0]    req_valid, req_ready, rsp_valid, rsp_ready, rsp_eq;
  logic [DW-1:0] req_op1 [2];
  logic [DW-1:0] req_op2 [2];
  logic [2:0]    req_ctrl [2];
  logic [DW-1:0] rsp_data [2];
  logic [DW-1:0] alu_op1, alu_op2, alu_imm, alu_out;
  logic          alu_src, alu_eq;
  logic [2:0]    alu_ctrl;

  int errors = 0;
  int checks = 0;
  bit model_last;

  function automatic logic [DW-1:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [2:0] c);
    case (c)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      default: return '0;
    endcase
  endfunction

  assign alu_out = ref_alu(alu_op1, alu_op2, alu_ctrl);
  assign alu_eq  = (alu_op1 == alu_op2);

`ifdef ALU_ARB_STATS_EN
  logic          stats_clr;
  logic [15:0]   g0, g1;
  logic [1:0]    w0, w1;
  logic [1:0]    x_req_ready, x_rsp_valid, x_rsp_eq;
  logic [DW-1:0] x_rsp_data0, x_rsp_data1, x_alu_op1, x_alu_op2, x_alu_imm, x_alu_out;
  logic [2:0]    x_alu_ctrl;
  logic          x_alu_src, x_alu_eq;
  assign x_alu_out = ref_alu(x_alu_op1, x_alu_op2, x_alu_ctrl);
  assign x_alu_eq  = (x_alu_op1 == x_alu_op2);

  alu_rr_arbiter #(.DATA_W(DW), .CNT_W(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req_valid[0]), .req0_ready(x_req_ready[0]), .req0_op1(req_op1[0]),
    .req0_op2(req_op2[0]), .req0_ctrl(req_ctrl[0]),
    .req1_valid(req_valid[1]), .req1_ready(x_req_ready[1]), .req1_op1(req_op1[1]),
    .req1_op2(req_op2[1]), .req1_ctrl(req_ctrl[1]),
    .rsp0_valid(x_rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_data(x_rsp_data0), .rsp0_eq(x_rsp_eq[0]),
    .rsp1_valid(x_rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_data(x_rsp_data1), .rsp1_eq(x_rsp_eq[1]),
    .stats_clr(stats_clr), .grant0_cnt(w0), .grant1_cnt(w1),
    .alu_op1(x_alu_op1), .alu_op2(x_alu_op2), .alu_imm(x_alu_imm), .alu_src(x_alu_src),
    .alu_ctrl(x_alu_ctrl), .alu_out(x_alu_out), .alu_eq(x_alu_eq)
  );
`endif

  alu_rr_arbiter #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_op1(req_op1[0]),
    .req0_op2(req_op2[0]), .req0_ctrl(req_ctrl[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_op1(req_op1[1]),
    .req1_op2(req_op2[1]), .req1_ctrl(req_ctrl[1]),
    .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_data(rsp_data[0]), .rsp0_eq(rsp_eq[0]),
    .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_data(rsp_data[1]), .rsp1_eq(rsp_eq[1]),
`ifdef ALU_ARB_STATS_EN
    .stats_clr(stats_clr), .grant0_cnt(g0), .grant1_cnt(g1),
`endif
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_imm(alu_imm), .alu_src(alu_src),
    .alu_ctrl(alu_ctrl), .alu_out(alu_out), .alu_eq(alu_eq)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    for (int r = 0; r < 2; r++) begin req_op1[r] = '0; req_op2[r] = '0; req_ctrl[r] = '0; end
`ifdef ALU_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    tick; tick;
    checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin errors++;
      $display("FAIL reset_handshake: ready=%b rsp_valid=%b expected 00/00", req_ready, rsp_valid); end
    checks++; if (rsp_data[0] !== '0 || rsp_data[1] !== '0 || rsp_eq !== 2'b00) begin errors++;
      $display("FAIL reset_rsp: data0=%h data1=%h eq=%b expected 0", rsp_data[0], rsp_data[1], rsp_eq); end
    checks++; if (alu_op1 !== '0 || alu_op2 !== '0 || alu_ctrl !== 3'b000) begin errors++;
      $display("FAIL reset_alu: op1=%h op2=%h ctrl=%b expected 0", alu_op1, alu_op2, alu_ctrl); end
    checks++; if (alu_imm !== '0 || alu_src !== 1'b0) begin errors++;
      $display("FAIL reset_tied: imm=%h src=%b expected 0", alu_imm, alu_src); end
    rst_n = 1'b1;
    model_last = 1'b1;
    tick;
    req_valid = 2'b11; #1;
    checks++; if (req_ready !== 2'b01) begin errors++;
      $display("FAIL reset_first_contention: ready=%b expected 01", req_ready); end
    req_valid = 2'b00; #1;
  endtask

  task automatic test_single(input int n, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [2:0] c);
    logic [DW-1:0] exp_d;
    logic          exp_e;
    logic [1:0]    oh;
    exp_d = ref_alu(a, b, c);
    exp_e = (a == b);
    oh    = (n == 0) ? 2'b01 : 2'b10;
    req_op1[n] = a; req_op2[n] = b; req_ctrl[n] = c; req_valid[n] = 1'b1; #1;
    checks++; if (req_ready !== oh) begin errors++;
      $display("FAIL single_ready: ready=%b expected %b", req_ready, oh); end
    model_last = n[0];
    tick;
    // Scribble the request inputs: only the handshake sample may matter.
    req_valid[n] = 1'b0; req_op1[n] = $urandom; req_op2[n] = $urandom; req_ctrl[n] = 3'($urandom_range(7, 0));
    #1;
    checks++; if (alu_op1 !== a || alu_op2 !== b || alu_ctrl !== c) begin errors++;
      $display("FAIL single_alu_drive: op1=%h op2=%h ctrl=%b expected %h %h %b", alu_op1, alu_op2, alu_ctrl, a, b, c); end
    checks++; if (rsp_valid !== 2'b00) begin errors++;
      $display("FAIL single_early_rsp: rsp_valid=%b expected 00", rsp_valid); end
    tick;
    checks++; if (rsp_valid !== oh) begin errors++;
      $display("FAIL single_rsp_valid: rsp_valid=%b expected %b", rsp_valid, oh); end
    checks++; if (rsp_data[n] !== exp_d || rsp_eq[n] !== exp_e) begin errors++;
      $display("FAIL single_rsp_data: data=%h eq=%b expected %h %b", rsp_data[n], rsp_eq[n], exp_d, exp_e); end
    rsp_ready[n] = 1'b1; tick; rsp_ready[n] = 1'b0;
    checks++; if (rsp_valid !== 2'b00) begin errors++;
      $display("FAIL single_rsp_done: rsp_valid=%b expected 00", rsp_valid); end
  endtask

  task automatic test_random;
    for (int k = 0; k < 6; k++) begin
      logic [DW-1:0] a;
      a = $urandom;
      test_single(int'($urandom_range(1, 0)), a, (k % 3 == 0) ? a : DW'($urandom), 3'($urandom_range(7, 0)));
    end
  endtask

  task automatic test_fairness;
    logic [DW-1:0] pa [2];
    logic [DW-1:0] pb [2];
    logic [2:0]    pc [2];
    int            g;
    logic [1:0]    oh;
    for (int r = 0; r < 2; r++) begin pa[r] = $urandom; pb[r] = $urandom; pc[r] = 3'($urandom_range(3, 0)); end
    pb[1] = pa[1];
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < 2; r++) begin req_op1[r] = pa[r]; req_op2[r] = pb[r]; req_ctrl[r] = pc[r]; end
      req_valid = 2'b11; #1;
      g  = model_last ? 0 : 1;
      oh = (g == 0) ? 2'b01 : 2'b10;
      checks++; if (req_ready !== oh) begin errors++;
        $display("FAIL fair_grant%0d: ready=%b expected %b", k, req_ready, oh); end
      model_last = g[0];
      tick; tick;
      checks++; if (rsp_valid !== oh || rsp_data[g] !== ref_alu(pa[g], pb[g], pc[g]) || rsp_eq[g] !== (pa[g] == pb[g])) begin
        errors++;
        $display("FAIL fair_rsp%0d: rsp_valid=%b data=%h eq=%b expected %b %h %b", k, rsp_valid, rsp_data[g], rsp_eq[g],
                 oh, ref_alu(pa[g], pb[g], pc[g]), pa[g] == pb[g]); end
      rsp_ready = 2'b11; tick; rsp_ready = 2'b00;
      pa[g] = $urandom; pb[g] = $urandom; pc[g] = 3'($urandom_range(7, 0));
    end
    req_valid = 2'b00; #1;
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] a, b, exp_d, b1;
    a = $urandom; b = $urandom; exp_d = ref_alu(a, b, 3'b010);
    req_op1[0] = a; req_op2[0] = b; req_ctrl[0] = 3'b010; req_valid[0] = 1'b1; #1;
    model_last = 1'b0;
    tick; req_valid = 2'b00; tick;
    b1 = $urandom;
    req_op1[1] = b1; req_op2[1] = b1; req_ctrl[1] = 3'b000;
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (rsp_valid !== 2'b01 || rsp_data[0] !== exp_d || rsp_eq[0] !== (a == b)) begin errors++;
        $display("FAIL bp_hold%0d: rsp_valid=%b data=%h expected 01 %h", i, rsp_valid, rsp_data[0], exp_d); end
      checks++; if (req_ready !== 2'b00) begin errors++;
        $display("FAIL bp_no_accept%0d: ready=%b expected 00", i, req_ready); end
      tick;
    end
    rsp_ready[0] = 1'b1; tick; rsp_ready[0] = 1'b0; #1;
    checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b10) begin errors++;
      $display("FAIL bp_release: rsp_valid=%b ready=%b expected 00 10", rsp_valid, req_ready); end
    model_last = 1'b1;
    tick; req_valid = 2'b00; tick;
    checks++; if (rsp_valid !== 2'b10 || rsp_data[1] !== b1 + b1 || rsp_eq[1] !== 1'b1) begin errors++;
      $display("FAIL bp_next_rsp: rsp_valid=%b data=%h expected 10 %h", rsp_valid, rsp_data[1], b1 + b1); end
    rsp_ready[1] = 1'b1; tick; rsp_ready[1] = 1'b0;
  endtask

  task automatic test_reset_mid;
    req_op1[0] = 32'd9; req_op2[0] = 32'd9; req_ctrl[0] = 3'b000; req_valid[0] = 1'b1; #1;
    tick; req_valid = 2'b00;
    #2; rst_n = 1'b0; #1;
    checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin errors++;
      $display("FAIL rstmid_handshake: rsp_valid=%b ready=%b expected 00", rsp_valid, req_ready); end
    checks++; if (alu_op1 !== '0 || alu_op2 !== '0 || alu_ctrl !== 3'b000) begin errors++;
      $display("FAIL rstmid_alu: op1=%h op2=%h ctrl=%b expected 0", alu_op1, alu_op2, alu_ctrl); end
    checks++; if (rsp_data[0] !== '0 || rsp_eq !== 2'b00) begin errors++;
      $display("FAIL rstmid_rsp: data=%h eq=%b expected 0", rsp_data[0], rsp_eq); end
    tick; rst_n = 1'b1; model_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (rsp_valid !== 2'b00) begin errors++;
        $display("FAIL rstmid_no_rsp%0d: rsp_valid=%b expected 00", i, rsp_valid); end
    end
    req_op1[1] = 32'd1; req_op2[1] = 32'd2; req_ctrl[1] = 3'b000;
    req_valid = 2'b11; #1;
    checks++; if (req_ready !== 2'b01) begin errors++;
      $display("FAIL rstmid_contention: ready=%b expected 01", req_ready); end
    model_last = 1'b0;
    tick; req_valid = 2'b00; tick;
    checks++; if (rsp_valid !== 2'b01 || rsp_data[0] !== 32'd18 || rsp_eq[0] !== 1'b1) begin errors++;
      $display("FAIL rstmid_rsp_after: rsp_valid=%b data=%h expected 01 12", rsp_valid, rsp_data[0]); end
    rsp_ready[0] = 1'b1; tick; rsp_ready[0] = 1'b0;
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats;
    stats_clr = 1'b1; tick; stats_clr = 1'b0; #1;
    checks++; if (g0 !== 16'd0 || g1 !== 16'd0) begin errors++;
      $display("FAIL stats_clear: g0=%0d g1=%0d expected 0 0", g0, g1); end
    for (int i = 0; i < 3; i++) test_single(0, $urandom, $urandom, 3'b000);
    for (int i = 0; i < 2; i++) test_single(1, $urandom, $urandom, 3'b001);
    checks++; if (g0 !== 16'd3 || g1 !== 16'd2) begin errors++;
      $display("FAIL stats_count: g0=%0d g1=%0d expected 3 2", g0, g1); end
    req_op1[1] = 32'd4; req_op2[1] = 32'd1; req_ctrl[1] = 3'b001; req_valid[1] = 1'b1; stats_clr = 1'b1; #1;
    model_last = 1'b1;
    tick; req_valid = 2'b00; stats_clr = 1'b0; #1;
    checks++; if (g0 !== 16'd0 || g1 !== 16'd0) begin errors++;
      $display("FAIL stats_clr_wins: g0=%0d g1=%0d expected 0 0", g0, g1); end
    tick;
    checks++; if (rsp_valid !== 2'b10 || rsp_data[1] !== 32'd3) begin errors++;
      $display("FAIL stats_clr_rsp: rsp_valid=%b data=%h expected 10 3", rsp_valid, rsp_data[1]); end
    rsp_ready[1] = 1'b1; tick; rsp_ready[1] = 1'b0;
    for (int i = 0; i < 5; i++) test_single(0, $urandom, $urandom, 3'b011);
    checks++; if (g0 !== 16'd5 || g1 !== 16'd0) begin errors++;
      $display("FAIL stats_five: g0=%0d g1=%0d expected 5 0", g0, g1); end
    checks++; if (w0 !== 2'd1 || w1 !== 2'd0) begin errors++;
      $display("FAIL stats_wrap: w0=%0d w1=%0d expected 1 0", w0, w1); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single(0, 32'd5, 32'd3, 3'b000);
    test_single(1, 32'd7, 32'd7, 3'b001);
    test_single(1, 32'h0000_00F0, 32'h0000_000F, 3'b011);
    test_single(0, 32'h1234, 32'h1234, 3'b101);
    test_random;
    test_fairness;
    test_backpressure;
    test_reset_mid;
`ifdef ALU_ARB_STATS_EN
    test_stats;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
